// File: rtl/data_mem_access_unit.sv
// Data memory initiator: turns one load/store request into one data_memory access cycle and returns a response.
// Latency: request accepted at edge N, memory accessed during N..N+1, response valid from edge N+1.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready. `DMAU_STATS_EN adds load/store counters.
module data_mem_access_unit #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [REGBITS-1:0] req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_is_store,
    output logic [REGBITS-1:0] mem_addr,
    output logic [WIDTH-1:0]   mem_w_data,
    output logic               mem_wr,
    output logic               mem_rd,
    input  logic [WIDTH-1:0]   mem_r_data
`ifdef DMAU_STATS_EN
    ,
    output logic [15:0]        load_count,
    output logic [15:0]        store_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_we;
    logic [REGBITS-1:0] r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_is_store;
    logic               w_accept;

    // State register; reset aborts any access in flight and clears mem_wr at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs; strobes come from the state register only
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_wr       = r_we;
                mem_rd       = ~r_we;
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request latch: captured only on acceptance so later req_* changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Response capture at the closing edge of ACCESS; held stable through RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data     <= '0;
            r_rsp_is_store <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_rsp_data     <= r_we ? '0 : mem_r_data;
            r_rsp_is_store <= r_we;
        end
    end

    assign mem_addr     = r_addr;
    assign mem_w_data   = r_wdata;
    assign rsp_data     = r_rsp_data;
    assign rsp_is_store = r_rsp_is_store;

`ifdef DMAU_STATS_EN
    logic [15:0] r_load_count;
    logic [15:0] r_store_count;

    // Saturating access counters, bumped as each ACCESS cycle completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_count  <= '0;
            r_store_count <= '0;
        end else if (r_state == ACCESS) begin
            if (r_we) begin
                if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
            end else begin
                if (r_load_count != 16'hFFFF) r_load_count <= r_load_count + 16'd1;
            end
        end
    end

    assign load_count  = r_load_count;
    assign store_count = r_store_count;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a behavioural data memory.
// Memory reads combinationally; unwritten words read as {8'hC0, addr}.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
module tb_data_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_is_store;
    logic [7:0]  mem_addr;
    logic [15:0] mem_w_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [15:0] mem_r_data;
`ifdef DMAU_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
`endif

    int errors = 0;
    int checks = 0;

    data_mem_access_unit #(.WIDTH(16), .REGBITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_is_store (rsp_is_store),
        .mem_addr     (mem_addr),
        .mem_w_data   (mem_w_data),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_r_data   (mem_r_data)
`ifdef DMAU_STATS_EN
        ,
        .load_count   (load_count),
        .store_count  (store_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: overlay of written words on a fixed default pattern
    logic        mem_clr;
    logic [255:0] mem_vld;
    logic [15:0] mem_arr [256];

    always @(posedge clk or posedge mem_clr) begin
        if (mem_clr) begin
            mem_vld <= '0;
        end else if (mem_wr) begin
            mem_vld[mem_addr]  <= 1'b1;
            mem_arr[mem_addr]  <= mem_w_data;
        end
    end

    assign mem_r_data = mem_vld[mem_addr] ? mem_arr[mem_addr] : {8'hC0, mem_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full request with rsp_ready held high; checks ACCESS, RESP and return to IDLE
    task automatic run_req(input string tag, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rsp);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 8'hEE;
        req_wdata = 16'hDEAD;
        check({tag, ".acc_wr"},    {31'd0, mem_wr},    {31'd0, we});
        check({tag, ".acc_rd"},    {31'd0, mem_rd},    {31'd0, ~we});
        check({tag, ".acc_addr"},  {24'd0, mem_addr},  {24'd0, addr});
        if (we) check({tag, ".acc_wdata"}, {16'd0, mem_w_data}, {16'd0, wdata});
        check({tag, ".acc_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, ".acc_rvld"},  {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".rsp_vld"},   {31'd0, rsp_valid},    32'd1);
        check({tag, ".rsp_data"},  {16'd0, rsp_data},     {16'd0, exp_rsp});
        check({tag, ".rsp_st"},    {31'd0, rsp_is_store}, {31'd0, we});
        check({tag, ".rsp_wr"},    {31'd0, mem_wr},       32'd0);
        check({tag, ".rsp_rd"},    {31'd0, mem_rd},       32'd0);
        check({tag, ".rsp_ready"}, {31'd0, req_ready},    32'd0);
        @(posedge clk); #1;
        check({tag, ".idle_vld"},   {31'd0, rsp_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, ".idle_addr"},  {24'd0, mem_addr},  {24'd0, addr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_clr   = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        #1;
        mem_clr = 1'b0;
        check("rst.req_ready", {31'd0, req_ready}, 32'd0);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.mem_wr",    {31'd0, mem_wr},    32'd0);
        check("rst.mem_rd",    {31'd0, mem_rd},    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel.req_ready",  {31'd0, req_ready},    32'd1);
        check("rel.rsp_valid",  {31'd0, rsp_valid},    32'd0);
        check("rel.rsp_data",   {16'd0, rsp_data},     32'd0);
        check("rel.rsp_st",     {31'd0, rsp_is_store}, 32'd0);
        check("rel.mem_addr",   {24'd0, mem_addr},     32'd0);
        check("rel.mem_wdata",  {16'd0, mem_w_data},   32'd0);
        check("rel.mem_wr",     {31'd0, mem_wr},       32'd0);
        check("rel.mem_rd",     {31'd0, mem_rd},       32'd0);

        // Store then load of the same address: load sees the new data
        run_req("st10", 1'b1, 8'h10, 16'hBEEF, 16'h0000);
        run_req("ld10", 1'b0, 8'h10, 16'h0000, 16'hBEEF);

        // Load with response stalled 5 cycles; a competing store must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h30;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_wdata = 16'hFFFF;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("stall.rsp_vld",   {31'd0, rsp_valid}, 32'd1);
            check("stall.rsp_data",  {16'd0, rsp_data},  32'h0000C030);
            check("stall.req_ready", {31'd0, req_ready}, 32'd0);
            check("stall.mem_wr",    {31'd0, mem_wr},    32'd0);
            @(posedge clk); #1;
        end
        check("stall.rsp_vld_end", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall.release_vld", {31'd0, rsp_valid}, 32'd0);
        check("stall.release_rdy", {31'd0, req_ready}, 32'd1);
        run_req("ld30", 1'b0, 8'h30, 16'h0000, 16'hC030);

        // Reset during a store's ACCESS cycle: the write must not happen
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmid.acc_wr", {31'd0, mem_wr}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rmid.wr_drop",   {31'd0, mem_wr},    32'd0);
        check("rmid.rsp_vld",   {31'd0, rsp_valid}, 32'd0);
        check("rmid.req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmid.rel_ready", {31'd0, req_ready}, 32'd1);
        check("rmid.rel_addr",  {24'd0, mem_addr},  32'd0);
        run_req("ld20", 1'b0, 8'h20, 16'h0000, 16'hC020);

        // Boundary addresses and further store/load pairs
        run_req("st40", 1'b1, 8'h40, 16'hABCD, 16'h0000);
        run_req("stFF", 1'b1, 8'hFF, 16'h0001, 16'h0000);
        run_req("ldFF", 1'b0, 8'hFF, 16'h0000, 16'h0001);
        run_req("ld00", 1'b0, 8'h00, 16'h0000, 16'hC000);
        run_req("ld40", 1'b0, 8'h40, 16'h0000, 16'hABCD);

`ifdef DMAU_STATS_EN
        // Since the mid-operation reset: stores 0x40, 0xFF; loads 0x20, 0xFF, 0x00, 0x40
        check("stats.store", {16'd0, store_count}, 32'd2);
        check("stats.load",  {16'd0, load_count},  32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
